ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline register between EX (ALU, including the PADDSB subword-saturating adder) and MEM.
- Captures the ALU result, store data, destination register and control bits for the instruction leaving EX.
- Owns the architectural N/V/Z flag register, updated per opcode at EX→MEM commit.
- Handles stall (hold), flush (bubble) and a sticky halt indication.

Parameters:
DW, 16, datapath width
RW, 4, register-address width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold all stage state this cycle
flush  in  1  kill instruction in EX; insert bubble
ex_valid  in  1  EX holds a real instruction
ex_opcode  in  4  EX opcode
ex_alu_out  in  DW  ALU result (incl. PADDSB)
ex_store_data  in  DW  SW data
ex_rd  in  RW  destination register
ex_reg_wr  in  1  writes register file
ex_mem_rd  in  1  LW
ex_mem_wr  in  1  SW
ex_hlt  in  1  HLT
ex_n, ex_v, ex_z  in  1 each  ALU flag candidates
mem_valid  out  1  MEM holds a real instruction
mem_opcode  out  4  registered opcode
mem_alu_out  out  DW  registered result / address
mem_store_data  out  DW  registered store data
mem_rd  out  RW  registered destination
mem_reg_wr, mem_mem_rd, mem_mem_wr  out  1 each  registered controls, forced 0 when mem_valid=0
flags  out  3  {N,V,Z} architectural flag register
halted  out  1  sticky: HLT committed

Behaviour:
- Reset (rst=1 at edge): all outputs 0, flags=3'b000, halted=0. Reset overrides stall and flush and applies mid-operation.
- Commit condition: ex_valid & ~stall & ~flush & ~halted.
- Priority, highest first: rst > flush > stall > normal.
- Normal (~stall, ~flush): all mem_* register their ex_* inputs next edge; latency 1 cycle; mem_valid=ex_valid & ~halted.
- Stall (~flush): every mem_* register, flags and halted hold their values.
- Flush (with or without stall): next edge mem_valid=0, mem_reg_wr=mem_mem_rd=mem_mem_wr=0, mem_opcode=0, mem_alu_out=0, mem_store_data=0, mem_rd=0. No flag update, no halt.
- Bubble rule: ex_valid=0 in normal flow loads mem_valid=0 with all write enables 0. Data fields are don't-care but are loaded as 0.
- Flag update, on commit only, keyed on ex_opcode:
  - 0000 ADD, 0001 SUB: N<=ex_n, V<=ex_v, Z<=ex_z.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: Z<=ex_z; N and V hold.
  - All other opcodes, including 0111 PADDSB and 0011 RED: flags hold.
- flags is visible one cycle after commit. A branch in EX in the same cycle sees the pre-update value; bypass is handled elsewhere.
- Halt: commit of ex_hlt=1 loads mem_valid=1 and sets halted=1.
  - halted stays 1 until rst.
  - Once halted=1, commit is blocked: mem_valid=0 every following cycle, and flags are frozen.
- No arithmetic in this block; all widths pass through unchanged.

Optional Feature:
EXMEM_SAT_CNT_EN:
- When defined, the block adds two input ports: ex_op_a [DW-1:0] and ex_op_b [DW-1:0], the ALU operands.
- It also adds one output port: sat_cnt [15:0].
- On commit of opcode 0111, each 4-bit nibble i of the two operands is checked. Saturation is detected when the operand signs are equal and the raw 4-bit sum sign differs from them.
- If any nibble saturated, sat_cnt increments by 1. The counter saturates at 16'hFFFF and never wraps.
- sat_cnt resets to 0 and holds under stall and flush.
- When not defined, the block has none of these ports and none of this logic.

Test Plan:
- Reset/pass-through: rst 1 cycle, then ADD with alu_out=16'h1234, rd=3, reg_wr=1 → next cycle mem_alu_out=16'h1234, mem_rd=3, mem_reg_wr=1, mem_valid=1; all outputs 0 during reset.
- Flag rules, each applied in the cycle after the previous: SUB with n=1,v=1,z=0 → flags=3'b110; then XOR with z=1 → flags=3'b111; then PADDSB with n=0,v=0,z=0 → flags stay 3'b111.
- Stall/flush: ADD(z=1) issued with stall=1 for 2 cycles → outputs and flags unchanged; stall and flush both 1 → mem_valid=0, mem_reg_wr=0, flags unchanged.
- Halt: commit HLT, then ADD(z=1) → halted=1, mem_valid=0 on the ADD cycle, flags unchanged; assert rst → halted=0.
- Saturation counter (EXMEM_SAT_CNT_EN): PADDSB with op_a=16'h7000, op_b=16'h1000 → sat_cnt=1; op_a=16'h1111, op_b=16'h1111 → stays 1; preload near limit via 65535 saturating ops → holds at 16'hFFFF.
- Flushed saturation: PADDSB op_a=16'h8000, op_b=16'h8000 with flush=1 → sat_cnt unchanged, no flag change.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register. It owns the {N,V,Z} flag register and the sticky halt bit.
// Define EXMEM_SAT_CNT_EN to add the PADDSB nibble-saturation event counter (sat_cnt).
module ex_mem_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_alu_out,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_wr,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic          ex_hlt,
    input  logic          ex_n,
    input  logic          ex_v,
    input  logic          ex_z,
`ifdef EXMEM_SAT_CNT_EN
    input  logic [DW-1:0] ex_op_a,
    input  logic [DW-1:0] ex_op_b,
    output logic [15:0]   sat_cnt,
`endif
    output logic          mem_valid,
    output logic [3:0]    mem_opcode,
    output logic [DW-1:0] mem_alu_out,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_wr,
    output logic          mem_mem_rd,
    output logic          mem_mem_wr,
    output logic [2:0]    flags,
    output logic          halted
);

    logic          valid_q, valid_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] sdata_q, sdata_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          reg_wr_q, reg_wr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [2:0]    flags_q, flags_d;
    logic          halted_q, halted_d;
    logic          commit;

    assign commit = ex_valid & ~stall & ~flush & ~halted_q;

    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        alu_d    = alu_q;
        sdata_d  = sdata_q;
        rd_d     = rd_q;
        reg_wr_d = reg_wr_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        flags_d  = flags_q;
        halted_d = halted_q;

        // Flush, a bubble, or an instruction blocked by halt all load an all-zero slot.
        if (flush || (!stall && !(ex_valid && !halted_q))) begin
            valid_d  = 1'b0;
            opcode_d = '0;
            alu_d    = '0;
            sdata_d  = '0;
            rd_d     = '0;
            reg_wr_d = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
        end else if (!stall) begin
            valid_d  = 1'b1;
            opcode_d = ex_opcode;
            alu_d    = ex_alu_out;
            sdata_d  = ex_store_data;
            rd_d     = ex_rd;
            reg_wr_d = ex_reg_wr;
            mem_rd_d = ex_mem_rd;
            mem_wr_d = ex_mem_wr;
        end

        if (commit) begin
            case (ex_opcode)
                4'b0000, 4'b0001:                   flags_d = {ex_n, ex_v, ex_z};
                4'b0010, 4'b0100, 4'b0101, 4'b0110: flags_d = {flags_q[2:1], ex_z};
                default:                            flags_d = flags_q;
            endcase
            halted_d = halted_q | ex_hlt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            alu_q    <= '0;
            sdata_q  <= '0;
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            flags_q  <= 3'b000;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            alu_q    <= alu_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            reg_wr_q <= reg_wr_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            flags_q  <= flags_d;
            halted_q <= halted_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_opcode     = opcode_q;
    assign mem_alu_out    = alu_q;
    assign mem_store_data = sdata_q;
    assign mem_rd         = rd_q;
    assign mem_reg_wr     = reg_wr_q;
    assign mem_mem_rd     = mem_rd_q;
    assign mem_mem_wr     = mem_wr_q;
    assign flags          = flags_q;
    assign halted         = halted_q;

`ifdef EXMEM_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        any_sat;

    // Signed 4-bit lane overflow: operands agree in sign, wrapped sum does not.
    function automatic logic nib_sat(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] s;
        s = a + b;
        return (a[3] == b[3]) && (s[3] != a[3]);
    endfunction

    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i < DW / 4; i++) begin
            any_sat = any_sat | nib_sat(ex_op_a[4*i +: 4], ex_op_b[4*i +: 4]);
        end
        sat_cnt_d = sat_cnt_q;
        if (commit && ex_opcode == 4'b0111 && any_sat && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a behavioural model, with directed literal checks.
// Saturation-counter tests run only when EXMEM_SAT_CNT_EN is defined.
module tb_ex_mem_stage;
    localparam int DW = 16;
    localparam int RW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall, flush, ex_valid;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] ex_alu_out, ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_hlt, ex_n, ex_v, ex_z;
    logic          mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, halted;
    logic [3:0]    mem_opcode;
    logic [DW-1:0] mem_alu_out, mem_store_data;
    logic [RW-1:0] mem_rd;
    logic [2:0]    flags;
`ifdef EXMEM_SAT_CNT_EN
    logic [DW-1:0] ex_op_a, ex_op_b;
    logic [15:0]   sat_cnt;
`endif

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_hlt(ex_hlt),
        .ex_n(ex_n), .ex_v(ex_v), .ex_z(ex_z),
`ifdef EXMEM_SAT_CNT_EN
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .sat_cnt(sat_cnt),
`endif
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
        .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .flags(flags), .halted(halted)
    );

    // Expected architectural view of the stage.
    logic          m_valid, m_rw, m_mr, m_mw, m_halted, m_fn, m_fv, m_fz;
    logic [3:0]    m_op;
    logic [DW-1:0] m_alu, m_sd;
    logic [RW-1:0] m_rd;
    logic [15:0]   m_sat;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit any_lane_overflow(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [3:0] na, nb;
        int s;
        for (int i = 0; i < DW / 4; i++) begin
            na = a[4*i +: 4];
            nb = b[4*i +: 4];
            s = int'(na) + int'(nb);
            if (s > 7 || s < -8) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        bit sat_ev;
        sat_ev = 1'b0;
`ifdef EXMEM_SAT_CNT_EN
        sat_ev = any_lane_overflow(ex_op_a, ex_op_b);
`endif
        if (rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_halted, m_fn, m_fv, m_fz} = '0;
            m_op = '0; m_alu = '0; m_sd = '0; m_rd = '0; m_sat = '0;
        end else if (flush) begin
            {m_valid, m_rw, m_mr, m_mw} = '0;
            m_op = '0; m_alu = '0; m_sd = '0; m_rd = '0;
        end else if (!stall) begin
            if (ex_valid && !m_halted) begin
                m_valid = 1'b1; m_op = ex_opcode; m_alu = ex_alu_out; m_sd = ex_store_data;
                m_rd = ex_rd; m_rw = ex_reg_wr; m_mr = ex_mem_rd; m_mw = ex_mem_wr;
                if (ex_opcode <= 4'd1) begin
                    m_fn = ex_n; m_fv = ex_v; m_fz = ex_z;
                end else if (ex_opcode == 4'd2 || (ex_opcode >= 4'd4 && ex_opcode <= 4'd6)) begin
                    m_fz = ex_z;
                end
                if (ex_hlt) m_halted = 1'b1;
                if (ex_opcode == 4'd7 && sat_ev && m_sat < 16'hFFFF) m_sat = m_sat + 16'd1;
            end else begin
                {m_valid, m_rw, m_mr, m_mw} = '0;
                m_op = '0; m_alu = '0; m_sd = '0; m_rd = '0;
            end
        end
    endtask

    // One clock: DUT and model advance on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("mem_valid", 32'(mem_valid), 32'(m_valid));
        chk("mem_opcode", 32'(mem_opcode), 32'(m_op));
        chk("mem_alu_out", 32'(mem_alu_out), 32'(m_alu));
        chk("mem_store_data", 32'(mem_store_data), 32'(m_sd));
        chk("mem_rd", 32'(mem_rd), 32'(m_rd));
        chk("mem_ctl", 32'({mem_reg_wr, mem_mem_rd, mem_mem_wr}), 32'({m_rw, m_mr, m_mw}));
        chk("flags", 32'(flags), 32'({m_fn, m_fv, m_fz}));
        chk("halted", 32'(halted), 32'(m_halted));
`ifdef EXMEM_SAT_CNT_EN
        chk("sat_cnt", 32'(sat_cnt), 32'(m_sat));
`endif
    endtask

    task automatic set_idle();
        stall = 0; flush = 0; ex_valid = 0; ex_opcode = '0; ex_alu_out = '0;
        ex_store_data = '0; ex_rd = '0; ex_reg_wr = 0; ex_mem_rd = 0; ex_mem_wr = 0;
        ex_hlt = 0; ex_n = 0; ex_v = 0; ex_z = 0;
`ifdef EXMEM_SAT_CNT_EN
        ex_op_a = '0; ex_op_b = '0;
`endif
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [DW-1:0] alu,
                             input logic [RW-1:0] rd, input logic rw,
                             input logic n, input logic v, input logic z);
        set_idle();
        ex_valid = 1; ex_opcode = op; ex_alu_out = alu; ex_rd = rd; ex_reg_wr = rw;
        ex_n = n; ex_v = v; ex_z = z;
    endtask

    initial begin
        {m_valid, m_rw, m_mr, m_mw, m_halted, m_fn, m_fv, m_fz} = '0;
        m_op = '0; m_alu = '0; m_sd = '0; m_rd = '0; m_sat = '0;
        set_idle();
        // Reset with junk on the inputs.
        rst = 1;
        set_instr(4'd0, 16'hBEEF, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        flush = 1; stall = 1;
        cycle();
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_alu", 32'(mem_alu_out), 32'd0);
        rst = 0;

        set_instr(4'd0, 16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("pt_alu", 32'(mem_alu_out), 32'h1234);
        chk("pt_rd", 32'(mem_rd), 32'd3);
        chk("pt_regwr", 32'(mem_reg_wr), 32'd1);
        chk("pt_valid", 32'(mem_valid), 32'd1);

        set_instr(4'd1, 16'h0001, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("flag_sub", 32'(flags), 32'b110);
        set_instr(4'd2, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("flag_xor", 32'(flags), 32'b111);
        set_instr(4'd7, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("flag_paddsb", 32'(flags), 32'b111);

        set_instr(4'd0, 16'h5555, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        stall = 1;
        cycle();
        cycle();
        chk("stall_flags", 32'(flags), 32'b111);
        chk("stall_op", 32'(mem_opcode), 32'd7);
        flush = 1;
        cycle();
        chk("sf_valid", 32'(mem_valid), 32'd0);
        chk("sf_regwr", 32'(mem_reg_wr), 32'd0);
        chk("sf_flags", 32'(flags), 32'b111);

        set_instr(4'hF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_hlt = 1;
        cycle();
        chk("hlt_valid", 32'(mem_valid), 32'd1);
        chk("hlt_halted", 32'(halted), 32'd1);
        set_instr(4'd0, 16'h0042, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("hlt_block_valid", 32'(mem_valid), 32'd0);
        chk("hlt_block_flags", 32'(flags), 32'b111);
        rst = 1;
        cycle();
        chk("hlt_rst", 32'(halted), 32'd0);
        rst = 0;

`ifdef EXMEM_SAT_CNT_EN
        set_instr(4'd7, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_op_a = 16'h7000; ex_op_b = 16'h1000;
        cycle();
        chk("sat_first", 32'(sat_cnt), 32'd1);
        ex_op_a = 16'h1111; ex_op_b = 16'h1111;
        cycle();
        chk("sat_none", 32'(sat_cnt), 32'd1);
        ex_op_a = 16'h8000; ex_op_b = 16'h8000; ex_n = 1; ex_v = 1; ex_z = 1; flush = 1;
        cycle();
        chk("sat_flush", 32'(sat_cnt), 32'd1);
        chk("sat_flush_flags", 32'(flags), 32'd0);
        flush = 0; ex_op_a = 16'h7000; ex_op_b = 16'h1000;
        for (int i = 0; i < 65536; i++) cycle();
        chk("sat_limit", 32'(sat_cnt), 32'hFFFF);
        rst = 1;
        cycle();
        rst = 0;
`endif

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_opcode = 4'($urandom_range(0, 15));
            ex_alu_out = 16'($urandom);
            ex_store_data = 16'($urandom);
            ex_rd = 4'($urandom);
            ex_reg_wr = 1'($urandom);
            ex_mem_rd = 1'($urandom);
            ex_mem_wr = 1'($urandom);
            ex_hlt = (ex_opcode == 4'hF) && ($urandom_range(0, 3) == 0);
            ex_n = 1'($urandom);
            ex_v = 1'($urandom);
            ex_z = 1'($urandom);
`ifdef EXMEM_SAT_CNT_EN
            ex_op_a = 16'($urandom);
            ex_op_b = 16'($urandom);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
